// File: rtl/pcs_tx_seq_if.sv
// Block-in / word-out bundle of the 64b/66b TX sequencer.
// The master drives blocks in and observes the scrambler-side words; the slave is the sequencer.
interface pcs_tx_seq_if #(
    parameter int LEN   = 32,
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic             in_ctrl_i;
    logic [63:0]      in_data_i;
    logic             scram_valid_o;
    logic [LEN-1:0]   scram_data_o;
    logic [1:0]       head_o;
    logic             head_valid_o;
    logic [5:0]       seq_o;
    logic [CNT_W-1:0] idle_cnt_o;

    modport master (
        output in_valid_i, in_ctrl_i, in_data_i,
        input  in_ready_o, scram_valid_o, scram_data_o, head_o, head_valid_o, seq_o, idle_cnt_o
    );

    modport slave (
        input  in_valid_i, in_ctrl_i, in_data_i,
        output in_ready_o, scram_valid_o, scram_data_o, head_o, head_valid_o, seq_o, idle_cnt_o
    );
endinterface

// File: rtl/pcs_tx_seq.sv
// TX block sequencer: splits 64-bit blocks into two 32-bit scrambler words, emits the sync header
// and leaves one pause slot per gearbox period; IDLE control blocks fill input underflow.
module pcs_tx_seq #(
    parameter int          LEN        = 32,
    parameter int          GB_PERIOD  = 33,
    parameter logic [63:0] IDLE_BLOCK = 64'h1e,
    parameter int          CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    pcs_tx_seq_if.slave   bus
);
    localparam logic [1:0] S_LOW   = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [5:0] LAST_SLOT = 6'(GB_PERIOD - 1);

    logic [5:0]       seq_reg;
    logic [5:0]       seq_next;
    logic [1:0]       state;
    logic [LEN-1:0]   upper_reg;
    logic [LEN-1:0]   data_reg;
    logic [1:0]       head_reg;
    logic             head_valid_reg;
    logic             scram_valid_reg;
    logic [5:0]       seq_out_reg;
    logic [CNT_W-1:0] idle_cnt_reg;

    logic             take_idle;
    logic [63:0]      blk_next;
    logic [1:0]       hdr_next;
    logic [LEN-1:0]   blk_word [2];

    // The slot number alone determines what this cycle does; no separate state register.
    always_comb begin
        state = S_LOW;
        if (seq_reg == LAST_SLOT) begin
            state = S_PAUSE;
        end else if (seq_reg[0]) begin
            state = S_HIGH;
        end
    end

    assign seq_next  = (seq_reg == LAST_SLOT) ? 6'd0 : seq_reg + 6'd1;
    assign take_idle = ~bus.in_valid_i;
    assign blk_next  = take_idle ? IDLE_BLOCK : bus.in_data_i;
    assign hdr_next  = take_idle ? 2'b10 : {bus.in_ctrl_i, ~bus.in_ctrl_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_split
        assign blk_word[gi] = blk_next[gi*LEN +: LEN];
    end

    assign bus.in_ready_o = ~reset & (state == S_LOW);

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_reg         <= 6'd0;
            seq_out_reg     <= 6'd0;
            upper_reg       <= '0;
            data_reg        <= '0;
            head_reg        <= 2'b00;
            head_valid_reg  <= 1'b0;
            scram_valid_reg <= 1'b0;
            idle_cnt_reg    <= '0;
        end else begin
            seq_reg     <= seq_next;
            seq_out_reg <= seq_reg;
            case (state)
                S_LOW: begin
                    data_reg        <= blk_word[0];
                    upper_reg       <= blk_word[1];
                    head_reg        <= hdr_next;
                    head_valid_reg  <= 1'b1;
                    scram_valid_reg <= 1'b1;
                    if (take_idle && (idle_cnt_reg != '1)) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                S_HIGH: begin
                    data_reg        <= upper_reg;
                    head_valid_reg  <= 1'b0;
                    scram_valid_reg <= 1'b1;
                end
                default: begin
                    // Pause slot: the gearbox drains; data and header simply hold.
                    head_valid_reg  <= 1'b0;
                    scram_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scram_valid_o = scram_valid_reg;
    assign bus.scram_data_o  = data_reg;
    assign bus.head_o        = head_reg;
    assign bus.head_valid_o  = head_valid_reg;
    assign bus.seq_o         = seq_out_reg;
    assign bus.idle_cnt_o    = idle_cnt_reg;
endmodule

// File: tb/tb_pcs_tx_seq.sv
// Directed bench for pcs_tx_seq: a cycle-indexed model predicts every output each cycle,
// plus literal expectations for the named scenarios and a small-counter build for saturation.
module tb_pcs_tx_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pcs_tx_seq_if #(.LEN(32), .CNT_W(16)) bus_m ();
    pcs_tx_seq_if #(.LEN(32), .CNT_W(4))  bus_s ();

    pcs_tx_seq #(.LEN(32), .GB_PERIOD(33), .IDLE_BLOCK(64'h1e), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus_m.slave)
    );
    pcs_tx_seq #(.LEN(32), .GB_PERIOD(33), .IDLE_BLOCK(64'h1e), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .bus(bus_s.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle t after reset release is gearbox slot t mod 33.
    int          t = 0;
    bit          model_started = 0;
    logic        m_valid = 0, m_hv = 0;
    logic [31:0] m_data = 0, m_hi = 0;
    logic [1:0]  m_head = 0;
    logic [5:0]  m_seq = 0;
    int          m_idle = 0;
    int          slot;
    logic [63:0] blk;

    initial forever begin
        @(posedge clk);
        model_started = 1;
        if (reset) begin
            t = 0; m_valid = 0; m_hv = 0; m_data = 0; m_hi = 0;
            m_head = 0; m_seq = 0; m_idle = 0;
        end else begin
            slot  = t % 33;
            m_seq = 6'(slot);
            if (slot == 32) begin
                m_valid = 0;
                m_hv    = 0;
            end else if (slot % 2 == 0) begin
                if (bus_m.in_valid_i) begin
                    blk    = bus_m.in_data_i;
                    m_head = bus_m.in_ctrl_i ? 2'b10 : 2'b01;
                end else begin
                    blk    = 64'h1e;
                    m_head = 2'b10;
                    if (m_idle < 65535) m_idle++;
                end
                m_data  = blk[31:0];
                m_hi    = blk[63:32];
                m_valid = 1;
                m_hv    = 1;
            end else begin
                m_data  = m_hi;
                m_valid = 1;
                m_hv    = 0;
            end
            t++;
        end
    end

    bit watch_dead = 0;
    bit dead_seen  = 0;
    logic exp_ready;

    initial forever begin
        @(negedge clk);
        if (model_started) begin
            exp_ready = !reset && ((t % 33) < 32) && ((t % 33) % 2 == 0);
            check("ready",      bus_m.in_ready_o,    exp_ready);
            check("valid",      bus_m.scram_valid_o, m_valid);
            check("data",       bus_m.scram_data_o,  m_data);
            check("head",       bus_m.head_o,        m_head);
            check("head_valid", bus_m.head_valid_o,  m_hv);
            check("seq",        bus_m.seq_o,         m_seq);
            check("idle_cnt",   bus_m.idle_cnt_o,    64'(m_idle));
            if (watch_dead && bus_m.scram_valid_o && bus_m.scram_data_o == 32'hdeadbeef)
                dead_seen = 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int hs, pauses, idle0;

    initial begin
        bus_m.in_valid_i = 0; bus_m.in_ctrl_i = 0; bus_m.in_data_i = 0;
        bus_s.in_valid_i = 0; bus_s.in_ctrl_i = 0; bus_s.in_data_i = 0;

        // 1: reset held 3 cycles
        repeat (3) @(negedge clk);
        check("rst_valid", bus_m.scram_valid_o, 0);
        check("rst_hv",    bus_m.head_valid_o,  0);
        check("rst_ready", bus_m.in_ready_o,    0);
        check("rst_seq",   bus_m.seq_o,         0);
        check("rst_idle",  bus_m.idle_cnt_o,    0);
        reset = 0;
        $display("txn reset released");

        // 2: underflow inserts IDLE
        @(negedge clk);
        check("idle_lo",   bus_m.scram_data_o, 32'h0000001e);
        check("idle_head", bus_m.head_o,       2'b10);
        check("idle_hv",   bus_m.head_valid_o, 1);
        check("idle_cnt1", bus_m.idle_cnt_o,   1);
        @(negedge clk);
        check("idle_hi",   bus_m.scram_data_o, 32'h00000000);
        check("idle_hv2",  bus_m.head_valid_o, 0);
        $display("txn idle block 0x000000000000001e");

        // 3: data block
        bus_m.in_valid_i = 1; bus_m.in_ctrl_i = 0; bus_m.in_data_i = 64'h0123456789abcdef;
        check("d_ready", bus_m.in_ready_o, 1);
        @(negedge clk);
        bus_m.in_valid_i = 0;
        check("d_lo",   bus_m.scram_data_o, 32'h89abcdef);
        check("d_head", bus_m.head_o,       2'b01);
        check("d_hv",   bus_m.head_valid_o, 1);
        @(negedge clk);
        check("d_hi",   bus_m.scram_data_o, 32'h01234567);
        check("d_hv2",  bus_m.head_valid_o, 0);
        check("d_idle", bus_m.idle_cnt_o,   1);
        $display("txn data block 0x0123456789abcdef");

        // 4: continuous valid for 330 cycles
        hs = 0; pauses = 0;
        idle0 = int'(bus_m.idle_cnt_o);
        bus_m.in_valid_i = 1;
        for (int i = 0; i < 330; i++) begin
            bus_m.in_data_i = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
            bus_m.in_ctrl_i = i[0];
            if (bus_m.in_ready_o) hs++;
            @(negedge clk);
            if (!bus_m.scram_valid_o) pauses++;
        end
        bus_m.in_valid_i = 0;
        check("stream_hs",     64'(hs),     160);
        check("stream_pauses", 64'(pauses), 10);
        check("stream_idle",   64'(int'(bus_m.idle_cnt_o) - idle0), 0);
        $display("txn stream 330 cycles handshakes=%0d pauses=%0d", hs, pauses);

        // 5: valid raised in the pause slot
        for (int k = 0; k < 40 && (t % 33) != 32; k++) @(negedge clk);
        check("p_slot", 64'(t % 33), 32);
        bus_m.in_valid_i = 1; bus_m.in_ctrl_i = 1; bus_m.in_data_i = 64'h5555aaaa_12345678;
        check("p_ready0", bus_m.in_ready_o, 0);
        @(negedge clk);
        check("p_ready1", bus_m.in_ready_o,    1);
        check("p_pause",  bus_m.scram_valid_o, 0);
        @(negedge clk);
        bus_m.in_valid_i = 0;
        check("p_lo",   bus_m.scram_data_o, 32'h12345678);
        check("p_head", bus_m.head_o,       2'b10);
        @(negedge clk);
        check("p_hi",   bus_m.scram_data_o, 32'h5555aaaa);
        $display("txn pause-held block 0x5555aaaa12345678");

        // 6: reset between low and high word
        for (int k = 0; k < 40 && (t % 33) != 0; k++) @(negedge clk);
        bus_m.in_valid_i = 1; bus_m.in_ctrl_i = 0; bus_m.in_data_i = 64'hdeadbeef_cafef00d;
        @(negedge clk);
        bus_m.in_valid_i = 0;
        check("r_lo", bus_m.scram_data_o, 32'hcafef00d);
        reset = 1;
        watch_dead = 1;
        @(negedge clk);
        check("r_valid", bus_m.scram_valid_o, 0);
        check("r_seq",   bus_m.seq_o,         0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("r_slot0", bus_m.seq_o,        0);
        check("r_idle",  bus_m.scram_data_o, 32'h0000001e);
        repeat (40) @(negedge clk);
        check("r_dead_seen", 64'(dead_seen), 0);
        $display("txn reset mid-block 0xdeadbeefcafef00d");

        // 7: 4-bit counter saturates (20 idle blocks since the last reset)
        check("sat_small", bus_s.idle_cnt_o, 4'hf);
        $display("txn small idle counter=%0d", bus_s.idle_cnt_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
